exmem_stage: RTL and testbench

Execute stage plus EX/MEM pipeline register, sitting directly downstream of the decode/execute pipe (depipe).
- Consumes depipe's *_E outputs and applies forwarding muxes.
- Computes the ALU result and NZCV flags; MUL runs on an iterative 32-cycle multiplier that stalls the front end.
- Registers control and data into the *_M outputs for the memory stage.

---
 rtl/proc_pkg.sv | 36 +++
 rtl/mul_iter.sv | 67 ++++++
 rtl/exmem_stage.sv | 180 ++++++++++++++++++
 tb/tb_exmem_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types and constants for the execute / EX-MEM stage.
package proc_pkg;

  // ALU operation select carried in ALUctrl_E.
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_MUL = 4'b0111
  } alu_ctrl_t;

  // Forwarding mux select; code 2'b11 falls back to the register value.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_M   = 2'b01,
    FWD_W   = 2'b10
  } fwd_sel_t;

  // Iterative multiplier control states.
  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

  // Bit positions inside the 4-bit NZCV flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/mul_iter.sv
// Shift-and-add multiplier, one multiplier bit per clock.
// Returns the low WIDTH bits of mcand * mplier; abort wins over everything.
module mul_iter
  import proc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MUL_CYCLES - 1);

  mul_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;

  // Operand load on start, one add/shift step per BUSY cycle, single DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (abort_i) begin
      state_q <= MUL_IDLE;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (start_i) begin
            mcand_q  <= mcand_i;
            mplier_q <= mplier_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) state_q <= MUL_DONE;
        end
        MUL_DONE: state_q <= MUL_IDLE;
        default:  state_q <= MUL_IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q == MUL_BUSY);
  assign done_o    = (state_q == MUL_DONE);
  assign product_o = acc_q;

endmodule

// File: rtl/exmem_stage.sv
// Execute stage (forwarding, ALU, iterative MUL) and EX/MEM pipeline register.
module exmem_stage
  import proc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_E,
  input  logic             regw_E,
  input  logic             memw_E,
  input  logic             regmem_E,
  input  logic             ALUope_E,
  input  logic [3:0]       ALUctrl_E,
  input  logic [3:0]       regScr_E,
  input  logic [WIDTH-1:0] regA_E,
  input  logic [WIDTH-1:0] regB_E,
  input  logic [WIDTH-1:0] inm_E,
  input  logic [1:0]       fwdA_sel,
  input  logic [1:0]       fwdB_sel,
  input  logic [WIDTH-1:0] result_W,
  output logic             stall_E,
  output logic             regw_M,
  output logic             memw_M,
  output logic             regmem_M,
  output logic [3:0]       regScr_M,
  output logic [WIDTH-1:0] aluRes_M,
  output logic [WIDTH-1:0] wdata_M,
  output logic [3:0]       flags_M
);

  localparam int MSB = WIDTH - 1;
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] src_a, src_b, op_b;
  logic [WIDTH:0]   sum_add, sum_sub;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags, mul_flags;
  logic             alu_c, alu_v, alu_valid;
  logic             is_mul, mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_product;

  logic             regw_d, memw_d, regmem_d;
  logic [3:0]       regScr_d, flags_d;
  logic [WIDTH-1:0] aluRes_d, wdata_d;

  // Operand forwarding; code 11 behaves like 00.
  always_comb begin
    case (fwdA_sel)
      FWD_M:   src_a = aluRes_M;
      FWD_W:   src_a = result_W;
      default: src_a = regA_E;
    endcase
    case (fwdB_sel)
      FWD_M:   src_b = aluRes_M;
      FWD_W:   src_b = result_W;
      default: src_b = regB_E;
    endcase
  end

  assign op_b    = ALUope_E ? inm_E : src_b;
  assign sum_add = {1'b0, src_a} + {1'b0, op_b};
  // A + ~B + 1: the carry out is the inverted borrow of A - B.
  assign sum_sub = {1'b0, src_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};

  // Single-cycle ALU result plus NZCV; unknown codes give zero result and flags.
  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_valid = 1'b1;
    case (ALUctrl_E)
      ALU_ADD: begin
        alu_res = sum_add[MSB:0];
        alu_c   = sum_add[WIDTH];
        alu_v   = (src_a[MSB] == op_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
      end
      ALU_SUB: begin
        alu_res = sum_sub[MSB:0];
        alu_c   = sum_sub[WIDTH];
        alu_v   = (src_a[MSB] != op_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
      end
      ALU_AND: alu_res = src_a & op_b;
      ALU_OR:  alu_res = src_a | op_b;
      ALU_XOR: alu_res = src_a ^ op_b;
      ALU_SLL: alu_res = src_a << op_b[SHW-1:0];
      ALU_SRL: alu_res = src_a >> op_b[SHW-1:0];
      ALU_MUL: alu_res = '0;
      default: alu_valid = 1'b0;
    endcase
    alu_flags = '0;
    if (alu_valid) begin
      alu_flags[FLAG_N] = alu_res[MSB];
      alu_flags[FLAG_Z] = (alu_res == '0);
      alu_flags[FLAG_C] = alu_c;
      alu_flags[FLAG_V] = alu_v;
    end
  end

  // A MUL may only start from idle; flush kills it before it begins.
  assign is_mul    = (ALUctrl_E == ALU_MUL);
  assign mul_start = is_mul && !flush_E && !mul_busy && !mul_done;
  // Gated with rst_n so the front end is released the moment reset asserts.
  assign stall_E   = rst_n && (mul_start || mul_busy);

  mul_iter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .abort_i   (flush_E),
    .mcand_i   (src_a),
    .mplier_i  (op_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // MUL reports N and Z only.
  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_product[MSB];
    mul_flags[FLAG_Z] = (mul_product == '0);
  end

  // Next EX/MEM contents: bubble on flush or while the multiplier holds E.
  always_comb begin
    regw_d   = 1'b0;
    memw_d   = 1'b0;
    regmem_d = 1'b0;
    regScr_d = '0;
    aluRes_d = '0;
    wdata_d  = '0;
    flags_d  = '0;
    if (flush_E) begin
      regw_d = 1'b0;
    end else if (mul_done) begin
      regw_d   = regw_E;
      memw_d   = memw_E;
      regmem_d = regmem_E;
      regScr_d = regScr_E;
      aluRes_d = mul_product;
      wdata_d  = src_b;
      flags_d  = mul_flags;
    end else if (!(mul_start || mul_busy)) begin
      regw_d   = regw_E;
      memw_d   = memw_E;
      regmem_d = regmem_E;
      regScr_d = regScr_E;
      aluRes_d = alu_res;
      wdata_d  = src_b;
      flags_d  = alu_flags;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regw_M   <= 1'b0;
      memw_M   <= 1'b0;
      regmem_M <= 1'b0;
      regScr_M <= '0;
      aluRes_M <= '0;
      wdata_M  <= '0;
      flags_M  <= '0;
    end else begin
      regw_M   <= regw_d;
      memw_M   <= memw_d;
      regmem_M <= regmem_d;
      regScr_M <= regScr_d;
      aluRes_M <= aluRes_d;
      wdata_M  <= wdata_d;
      flags_M  <= flags_d;
    end
  end

endmodule

// File: tb/tb_exmem_stage.sv
// Self-checking bench for exmem_stage: directed vector table, random ops
// against an arithmetic reference model, and MUL / flush / reset sequences.
module tb_exmem_stage;

  typedef struct {
    logic        regw, memw, regmem, ope;
    logic [3:0]  ctrl, scr;
    logic [31:0] a, b, inm, w;
    logic [1:0]  fa, fb;
  } in_t;

  typedef struct {
    in_t         in;
    logic [31:0] res;
    logic [3:0]  fl;
    logic [31:0] wd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_E, regw_E, memw_E, regmem_E, ALUope_E;
  logic [3:0]  ALUctrl_E, regScr_E;
  logic [31:0] regA_E, regB_E, inm_E, result_W;
  logic [1:0]  fwdA_sel, fwdB_sel;
  logic        stall_E, regw_M, memw_M, regmem_M;
  logic [3:0]  regScr_M, flags_M;
  logic [31:0] aluRes_M, wdata_M;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_prev;

  always #5 clk = ~clk;

  exmem_stage #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush_E(flush_E),
    .regw_E(regw_E), .memw_E(memw_E), .regmem_E(regmem_E),
    .ALUope_E(ALUope_E), .ALUctrl_E(ALUctrl_E), .regScr_E(regScr_E),
    .regA_E(regA_E), .regB_E(regB_E), .inm_E(inm_E),
    .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel), .result_W(result_W),
    .stall_E(stall_E), .regw_M(regw_M), .memw_M(memw_M), .regmem_M(regmem_M),
    .regScr_M(regScr_M), .aluRes_M(aluRes_M), .wdata_M(wdata_M), .flags_M(flags_M)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic in_t mk(input logic [3:0] ctrl, input logic ope, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] inm, input logic [1:0] fa,
                             input logic [1:0] fb, input logic [31:0] w, input logic [3:0] scr,
                             input logic regw, input logic memw, input logic regmem);
    in_t x;
    x.ctrl = ctrl; x.ope = ope; x.a = a; x.b = b; x.inm = inm; x.fa = fa; x.fb = fb;
    x.w = w; x.scr = scr; x.regw = regw; x.memw = memw; x.regmem = regmem;
    return x;
  endfunction

  task automatic drive(input in_t x);
    ALUctrl_E = x.ctrl; ALUope_E = x.ope; regA_E = x.a; regB_E = x.b; inm_E = x.inm;
    fwdA_sel = x.fa; fwdB_sel = x.fb; result_W = x.w; regScr_E = x.scr;
    regw_E = x.regw; memw_E = x.memw; regmem_E = x.regmem;
  endtask

  // Reference: operation semantics computed with wide integer arithmetic.
  function automatic void model(input in_t x, input logic [31:0] prev_m, output logic [31:0] res,
                                output logic [3:0] fl, output logic [31:0] wd);
    logic [31:0] a, b, ob;
    longint unsigned ua, ub;
    longint sa, sb, sr;
    logic c, v, ok;
    a  = (x.fa == 2'd1) ? prev_m : (x.fa == 2'd2) ? x.w : x.a;
    b  = (x.fb == 2'd1) ? prev_m : (x.fb == 2'd2) ? x.w : x.b;
    ob = x.ope ? x.inm : b;
    wd = b;
    ua = {32'd0, a}; ub = {32'd0, ob};
    sa = longint'($signed(a)); sb = longint'($signed(ob));
    c = 1'b0; v = 1'b0; ok = 1'b1; res = 32'd0;
    case (x.ctrl)
      4'd0: begin ua = ua + ub; res = ua[31:0]; c = ua[32]; sr = sa + sb;
                  v = (sr != longint'($signed(res))); end
      4'd1: begin res = a - ob; c = (a >= ob); sr = sa - sb;
                  v = (sr != longint'($signed(res))); end
      4'd2: res = a & ob;
      4'd3: res = a | ob;
      4'd4: res = a ^ ob;
      4'd5: res = a << ob[4:0];
      4'd6: res = a >> ob[4:0];
      4'd7: begin ua = ua * ub; res = ua[31:0]; end
      default: ok = 1'b0;
    endcase
    fl = ok ? {res[31], (res == 32'd0), c, v} : 4'd0;
  endfunction

  task automatic check_m(input string tag, input in_t x, input logic [31:0] res,
                         input logic [3:0] fl, input logic [31:0] wd);
    chk({tag, ".regw"},   32'(regw_M),   32'(x.regw));
    chk({tag, ".memw"},   32'(memw_M),   32'(x.memw));
    chk({tag, ".regmem"}, 32'(regmem_M), 32'(x.regmem));
    chk({tag, ".scr"},    32'(regScr_M), 32'(x.scr));
    chk({tag, ".res"},    aluRes_M,      res);
    chk({tag, ".wdata"},  wdata_M,       wd);
    chk({tag, ".flags"},  32'(flags_M),  32'(fl));
  endtask

  task automatic nop();
    drive(mk(4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0));
  endtask

  // Run a MUL from the current cycle to its product on the M outputs.
  task automatic run_mul(input string tag, input in_t x);
    logic [31:0] res, wd;
    logic [3:0]  fl;
    int          stall_cnt, bubble_bad;
    logic        dropped;
    model(x, 32'd0, res, fl, wd);
    drive(x);
    #1;
    chk({tag, ".stall_start"}, 32'(stall_E), 32'd1);
    stall_cnt = stall_E ? 1 : 0;
    bubble_bad = 0;
    dropped = 1'b0;
    for (int i = 0; i < 40 && !dropped; i++) begin
      @(posedge clk); #1;
      if (stall_E) stall_cnt++;
      else dropped = 1'b1;
      if (regw_M || memw_M || regmem_M || regScr_M != 4'd0 || aluRes_M != 32'd0 ||
          wdata_M != 32'd0 || flags_M != 4'd0) bubble_bad++;
    end
    chk({tag, ".stall_released"}, 32'(dropped), 32'd1);
    chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'd33);
    chk({tag, ".bubbles"}, 32'(bubble_bad), 32'd0);
    @(posedge clk); #1;
    check_m(tag, x, res, fl, wd);
    $display("txn %s: mul %h x %h -> %h (stall %0d cycles)", tag, x.a, x.ope ? x.inm : x.b,
             aluRes_M, stall_cnt);
    nop();
  endtask

  vec_t vec [16];

  initial begin
    logic [31:0] r, wd;
    logic [3:0]  fl;
    in_t         x;

    // Directed vectors: {inputs, result, NZCV, store data}.
    vec[0]  = '{mk(4'h0, 0, 32'h0000FFFF, 32'h00000801, 0, 0, 0, 0, 4'd3, 1, 0, 0), 32'h00010800, 4'b0000, 32'h00000801};
    vec[1]  = '{mk(4'h2, 1, 32'h0000FFFF, 32'h0000DEAD, 32'h00000401, 0, 0, 0, 4'd4, 1, 0, 0), 32'h00000401, 4'b0000, 32'h0000DEAD};
    vec[2]  = '{mk(4'h1, 0, 32'd5, 32'd5, 0, 0, 0, 0, 4'd5, 1, 0, 0), 32'h0, 4'b0110, 32'd5};
    vec[3]  = '{mk(4'h0, 0, 32'h7FFFFFFF, 32'd1, 0, 0, 0, 0, 4'd6, 1, 0, 0), 32'h80000000, 4'b1001, 32'd1};
    vec[4]  = '{mk(4'h3, 0, 32'hF0, 32'h0F, 0, 0, 0, 0, 4'd7, 0, 1, 0), 32'hFF, 4'b0000, 32'h0F};
    vec[5]  = '{mk(4'h4, 0, 32'hFFFFFFFF, 32'h0000FFFF, 0, 0, 0, 0, 4'd8, 1, 0, 1), 32'hFFFF0000, 4'b1000, 32'h0000FFFF};
    vec[6]  = '{mk(4'h5, 1, 32'd1, 32'h77, 32'h24, 0, 0, 0, 4'd9, 1, 0, 0), 32'h10, 4'b0000, 32'h77};
    vec[7]  = '{mk(4'h6, 1, 32'h80000000, 32'd0, 32'h1F, 0, 0, 0, 4'd10, 1, 0, 0), 32'h1, 4'b0000, 32'h0};
    vec[8]  = '{mk(4'hA, 0, 32'd5, 32'd6, 0, 0, 0, 0, 4'd11, 1, 0, 0), 32'h0, 4'b0000, 32'd6};
    vec[9]  = '{mk(4'h1, 0, 32'd3, 32'd5, 0, 0, 0, 0, 4'd12, 1, 0, 0), 32'hFFFFFFFE, 4'b1000, 32'd5};
    vec[10] = '{mk(4'h0, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 0, 4'd13, 1, 0, 0), 32'h0, 4'b0110, 32'd1};
    vec[11] = '{mk(4'h0, 0, 32'd8, 32'd8, 0, 0, 0, 0, 4'd14, 1, 0, 0), 32'h10, 4'b0000, 32'd8};
    vec[12] = '{mk(4'h0, 0, 32'h999, 32'h777, 0, 2'd1, 2'd2, 32'h22, 4'd15, 1, 0, 0), 32'h32, 4'b0000, 32'h22};
    vec[13] = '{mk(4'h1, 0, 32'h80000000, 32'd1, 0, 0, 0, 0, 4'd1, 1, 0, 0), 32'h7FFFFFFF, 4'b0011, 32'd1};
    vec[14] = '{mk(4'h0, 0, 32'd5, 32'd6, 0, 2'd3, 2'd3, 32'h999, 4'd2, 1, 0, 0), 32'hB, 4'b0000, 32'd6};
    vec[15] = '{mk(4'h1, 1, 32'h10, 32'd3, 32'h10, 0, 0, 0, 4'd3, 1, 0, 0), 32'h0, 4'b0110, 32'd3};

    // Reset with a MUL sitting in E: outputs zero and no stall.
    rst_n = 1'b0; flush_E = 1'b0;
    drive(mk(4'h7, 0, 32'd3, 32'd7, 0, 0, 0, 0, 4'd1, 1, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check_m("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0), 32'd0, 4'd0, 32'd0);
    chk("reset.stall", 32'(stall_E), 32'd0);
    nop();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    foreach (vec[i]) begin
      drive(vec[i].in);
      @(posedge clk); #1;
      check_m($sformatf("vec%0d", i), vec[i].in, vec[i].res, vec[i].fl, vec[i].wd);
      $display("txn vec%0d: ctrl=%h res=%h flags=%b", i, vec[i].in.ctrl, aluRes_M, flags_M);
    end
    exp_prev = vec[15].res;

    // Random single-cycle ops including forwarding from M and W.
    for (int i = 0; i < 40; i++) begin
      x = mk(4'($urandom_range(0, 15)), 1'($urandom), $urandom, $urandom,
             (($urandom & 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
             2'($urandom), 2'($urandom), $urandom, 4'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
      if (x.ctrl == 4'd7) x.ctrl = 4'd1;
      if ($urandom_range(0, 3) == 0) begin x.b = x.a; x.inm = x.a; end
      model(x, exp_prev, r, fl, wd);
      drive(x);
      @(posedge clk); #1;
      check_m($sformatf("rnd%0d", i), x, r, fl, wd);
      $display("txn rnd%0d: ctrl=%h fa=%0d fb=%0d res=%h flags=%b", i, x.ctrl, x.fa, x.fb,
               aluRes_M, flags_M);
      exp_prev = r;
    end

    // Directed and random multiplies.
    run_mul("mul_1234x10", mk(4'h7, 0, 32'h00001234, 32'h00000010, 0, 0, 0, 0, 4'd9, 1, 0, 0));
    for (int i = 0; i < 3; i++) begin
      x = mk(4'h7, 1'($urandom), $urandom, $urandom, $urandom, 0, 0, 0, 4'($urandom), 1, 0, 0);
      run_mul($sformatf("mul_rnd%0d", i), x);
    end

    // Flush in the 10th BUSY cycle aborts the MUL.
    @(posedge clk); #1;
    drive(mk(4'h7, 0, 32'h00001234, 32'h00000010, 0, 0, 0, 0, 4'd5, 1, 0, 0));
    repeat (10) @(posedge clk);
    #1;
    chk("flush.stall_busy", 32'(stall_E), 32'd1);
    flush_E = 1'b1;
    @(posedge clk); #1;
    chk("flush.stall_after", 32'(stall_E), 32'd0);
    chk("flush.regw", 32'(regw_M), 32'd0);
    chk("flush.res", aluRes_M, 32'd0);
    $display("txn flush: stall=%0d regw_M=%0d", stall_E, regw_M);
    flush_E = 1'b0;
    x = mk(4'h0, 0, 32'd2, 32'd3, 0, 0, 0, 0, 4'd6, 1, 0, 0);
    drive(x);
    @(posedge clk); #1;
    check_m("post_flush_add", x, 32'd5, 4'b0000, 32'd3);
    $display("txn post_flush_add: res=%h", aluRes_M);

    // Asynchronous reset clears a valid M entry without waiting for an edge.
    x = mk(4'h0, 0, 32'h100, 32'h23, 0, 0, 0, 0, 4'd9, 1, 0, 0);
    drive(x);
    @(posedge clk); #1;
    chk("pre_rst.res", aluRes_M, 32'h123);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst.res", aluRes_M, 32'd0);
    chk("async_rst.regw", 32'(regw_M), 32'd0);
    chk("async_rst.scr", 32'(regScr_M), 32'd0);
    $display("txn async_rst: res=%h regw=%0d", aluRes_M, regw_M);
    nop();
    #2 rst_n = 1'b1;

    // Asynchronous reset mid-MUL, then a clean 3 x 7.
    @(posedge clk); #1;
    drive(mk(4'h7, 0, 32'h00001234, 32'h00000010, 0, 0, 0, 0, 4'd4, 1, 0, 0));
    repeat (5) @(posedge clk);
    #1;
    chk("mul_rst.stall_busy", 32'(stall_E), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("mul_rst.stall", 32'(stall_E), 32'd0);
    chk("mul_rst.res", aluRes_M, 32'd0);
    chk("mul_rst.regw", 32'(regw_M), 32'd0);
    $display("txn mul_rst: stall=%0d", stall_E);
    nop();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_mul("mul_3x7", mk(4'h7, 0, 32'd3, 32'd7, 0, 0, 0, 0, 4'd2, 1, 0, 0));
    chk("mul_3x7.value", aluRes_M, 32'h00000015);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
